ring_pe_port: RTL

- Network-side endpoint of the NIC-to-ring link: the ring's local (PE) port that a NIC's net_so/net_ro/net_do and net_si/net_ri/net_di connect to.
- Generates the polarity signal seen by the NIC.
- Buffers NIC-injected packets per virtual channel (VC) and presents them to the ring router.
- Buffers packets ejected from the ring per VC and hands them to the NIC.
- Instantiated once per ring node inside the ring, between the router core and the node's NIC.

---
 rtl/ring_pkg.sv | 23 ++
 rtl/ring_pe_port_if.sv | 31 +++
 rtl/ring_vc_buf.sv | 53 +++++
 rtl/ring_pe_port.sv | 89 ++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared ring-network constants: packet width, the VC and direction bit
// positions, the hop-field location, and a small VC helper.
package ring_pkg;

  localparam int DATA_W  = 64;
  localparam int VC_BIT  = DATA_W - 1;
  localparam int DIR_BIT = DATA_W - 2;

  // Hop count field carried in the low bits of the packet header.
  localparam int HOP_LSB = 0;
  localparam int HOP_W   = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

  // The VC that is drained in a cycle is always the one not being written.
  function automatic logic other_vc(input logic vc);
    return ~vc;
  endfunction

endpackage

// File: rtl/ring_pe_port_if.sv
// NIC-side and router-side handshake bundle of the ring PE port.
// master = the port itself, slave = the NIC/router environment around it.
interface ring_pe_port_if #(
  parameter int DATA_W = ring_pkg::DATA_W
);
  import ring_pkg::*;

  logic              pesi;
  logic              peri;
  logic [DATA_W-1:0] pedi;
  logic              peso;
  logic              pero;
  logic [DATA_W-1:0] pedo;
  logic              inj_valid;
  logic [DATA_W-1:0] inj_data;
  logic              inj_ready;
  logic              ej_valid;
  logic [DATA_W-1:0] ej_data;
  logic              ej_ready;

  modport master (
    input  pesi, pedi, pero, inj_ready, ej_valid, ej_data,
    output peri, peso, pedo, inj_valid, inj_data, ej_ready
  );

  modport slave (
    output pesi, pedi, pero, inj_ready, ej_valid, ej_data,
    input  peri, peso, pedo, inj_valid, inj_data, ej_ready
  );

endinterface

// File: rtl/ring_vc_buf.sv
// Two-entry buffer indexed by the cycle polarity: entry [pol] may be written
// this cycle, entry [~pol] may be read this cycle, so one entry is never
// written and drained in the same cycle.
module ring_vc_buf #(
  parameter int DATA_W = ring_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pol,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);
  import ring_pkg::*;

  logic [1:0]        full_q, full_d;
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic              rd_vc;

  assign rd_vc    = other_vc(pol);
  assign wr_ready = ~full_q[pol];
  assign rd_valid = full_q[rd_vc];
  assign rd_data  = data_q[rd_vc];

  // Fill the write-side entry on a write handshake, free the read-side one on a read.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_valid && wr_ready) begin
      full_d[pol] = 1'b1;
      data_d[pol] = wr_data;
    end
    if (rd_valid && rd_ready) begin
      full_d[rd_vc] = 1'b0;
    end
  end

  // Buffer state; reset empties both entries and clears their contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      data_q <= '{default: '0};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/ring_pe_port.sv
// Local (PE) port of a ring node: generates the polarity seen by the NIC,
// buffers NIC-injected and ring-ejected packets per VC, and counts traffic.
module ring_pe_port #(
  parameter int DATA_W = ring_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  ring_pe_port_if.master    pe,
  output logic              polarity,
  output logic [CNT_W-1:0]  inj_count,
  output logic [CNT_W-1:0]  ej_count
);
  import ring_pkg::*;

  logic              pol_q, pol_d;
  logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;
  logic [CNT_W-1:0]  ej_cnt_q, ej_cnt_d;

  logic              inj_wr_ready;
  logic [DATA_W-1:0] inj_wr_data;
  logic              ej_rd_valid;
  logic [DATA_W-1:0] ej_rd_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The NIC's VC bit is replaced by the polarity it was injected under.
  assign inj_wr_data = {pol_q, pe.pedi[DATA_W-2:0]};

  ring_vc_buf #(.DATA_W(DATA_W)) u_inj_buf (
    .clk      (clk),
    .reset    (reset),
    .pol      (pol_q),
    .wr_valid (pe.pesi),
    .wr_data  (inj_wr_data),
    .wr_ready (inj_wr_ready),
    .rd_valid (pe.inj_valid),
    .rd_data  (pe.inj_data),
    .rd_ready (pe.inj_ready)
  );

  ring_vc_buf #(.DATA_W(DATA_W)) u_ej_buf (
    .clk      (clk),
    .reset    (reset),
    .pol      (pol_q),
    .wr_valid (pe.ej_valid),
    .wr_data  (pe.ej_data),
    .wr_ready (pe.ej_ready),
    .rd_valid (ej_rd_valid),
    .rd_data  (ej_rd_data),
    .rd_ready (pe.pero)
  );

  assign pe.peri   = inj_wr_ready;
  assign pe.peso   = ej_rd_valid;
  assign pe.pedo   = ej_rd_valid ? ej_rd_data : '0;
  assign polarity  = pol_q;
  assign inj_count = inj_cnt_q;
  assign ej_count  = ej_cnt_q;

  // Polarity flips every cycle; counters step on each completed NIC transfer.
  always_comb begin
    pol_d     = ~pol_q;
    inj_cnt_d = inj_cnt_q;
    ej_cnt_d  = ej_cnt_q;
    if (pe.pesi && inj_wr_ready) begin
      inj_cnt_d = sat_inc(inj_cnt_q);
    end
    if (ej_rd_valid && pe.pero) begin
      ej_cnt_d = sat_inc(ej_cnt_q);
    end
  end

  // Polarity and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pol_q     <= 1'b0;
      inj_cnt_q <= '0;
      ej_cnt_q  <= '0;
    end else begin
      pol_q     <= pol_d;
      inj_cnt_q <= inj_cnt_d;
      ej_cnt_q  <= ej_cnt_d;
    end
  end

endmodule
